// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its control unit.
package fetch_pkg;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StFetch = 2'b01,
    StExec  = 2'b10
  } state_e;

  // PCSrc encodings, also driven by the control unit.
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_JAL = 2'b01;
  localparam logic [1:0] PCSRC_BR  = 2'b10;
  localparam logic [1:0] PCSRC_JR  = 2'b11;

  // Sequential PC increment in bytes.
  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection: sequential, jal, branch and jr targets.
module next_pc_mux
  import fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] ins_i,
  input  logic [1:0]  pc_src_i,
  input  logic        branch_taken_i,
  input  logic [31:0] reg_target_i,
  output logic [31:0] next_pc_o,
  output logic [31:0] pc_plus4_o
);

  logic [31:0] br_off;
  logic [31:0] br_target;
  logic        unused_bits;

  assign pc_plus4_o = pc_i + PC_STEP;
  // Sign-extended word offset, scaled to bytes.
  assign br_off     = {{14{ins_i[15]}}, ins_i[15:0], 2'b00};
  assign br_target  = pc_plus4_o + br_off;
  // Opcode bits and jr low bits do not take part in target selection.
  assign unused_bits = ^{ins_i[31:26], reg_target_i[1:0]};

  // Select the committed target; carries out of bit 31 are discarded.
  always_comb begin
    next_pc_o = pc_plus4_o;
    unique case (pc_src_i)
      PCSRC_SEQ: next_pc_o = pc_plus4_o;
      PCSRC_JAL: next_pc_o = {pc_plus4_o[31:28], ins_i[25:0], 2'b00};
      PCSRC_BR:  next_pc_o = branch_taken_i ? br_target : pc_plus4_o;
      PCSRC_JR:  next_pc_o = {reg_target_i[31:2], 2'b00};
      default:   next_pc_o = pc_plus4_o;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and instruction register, fetches over a valid
// handshake and holds the instruction for the control unit until PCWrite commits.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned HOLD_LIMIT = 3
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        PCWrite,
  input  logic [1:0]  PCSrc,
  input  logic        branch_taken,
  input  logic [31:0] reg_target,
  output logic [31:0] ins,
  output logic        ins_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired,
  output logic        fault
);

  localparam logic [3:0] HoldLimit = 4'(HOLD_LIMIT);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] retired_q, retired_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic        fault_q, fault_d;
  logic [31:0] next_pc;

  next_pc_mux u_next_pc_mux (
    .pc_i          (pc_q),
    .ins_i         (ins_q),
    .pc_src_i      (PCSrc),
    .branch_taken_i(branch_taken),
    .reg_target_i  (reg_target),
    .next_pc_o     (next_pc),
    .pc_plus4_o    (pc_plus4)
  );

  // Next-state logic for the FSM, PC, IR, retire/hold counters and sticky fault.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ins_d      = ins_q;
    retired_d  = retired_q;
    hold_cnt_d = hold_cnt_q;
    fault_d    = fault_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (imem_valid) begin
          ins_d   = imem_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        if (PCWrite) begin
          pc_d       = next_pc;
          retired_d  = retired_q + 32'd1;
          hold_cnt_d = 4'd0;
          state_d    = StFetch;
        end else begin
          if (hold_cnt_q != 4'hF) begin
            hold_cnt_d = hold_cnt_q + 4'd1;
          end
          // Flag a stalled control unit; the FSM keeps holding regardless.
          if (hold_cnt_d >= HoldLimit) begin
            fault_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset; reset abandons any outstanding fetch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      ins_q      <= 32'd0;
      retired_q  <= 32'd0;
      hold_cnt_q <= 4'd0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ins_q      <= ins_d;
      retired_q  <= retired_d;
      hold_cnt_q <= hold_cnt_d;
      fault_q    <= fault_d;
    end
  end

  assign imem_req  = (state_q == StFetch);
  assign ins_valid = (state_q == StExec);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ins       = ins_q;
  assign retired   = retired_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of single-round instructions plus
// hand-written two-round, hold-fault and mid-fetch reset sequences.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        PCWrite = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic        branch_taken = 1'b0;
  logic [31:0] reg_target = 32'd0;
  logic [31:0] ins;
  logic        ins_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired;
  logic        fault;

  int tests_run = 0;
  int tests_failed = 0;

  fetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .PCWrite     (PCWrite),
    .PCSrc       (PCSrc),
    .branch_taken(branch_taken),
    .reg_target  (reg_target),
    .ins         (ins),
    .ins_valid   (ins_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .retired     (retired),
    .fault       (fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  src;
    logic        taken;
    logic [31:0] target;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] exp_pc;
  logic [31:0] exp_ret;
  logic [31:0] held_ins;

  initial begin
    // Sequence walks the PC through every target kind, ending with a 32-bit wrap.
    vecs[0]  = '{32'h0000_0000, 2'b00, 1'b0, 32'h0,         32'h0000_0004};
    vecs[1]  = '{32'h0000_0000, 2'b11, 1'b0, 32'h0000_0200, 32'h0000_0200};
    vecs[2]  = '{32'h0800_0010, 2'b01, 1'b0, 32'h0,         32'h0000_0040};
    vecs[3]  = '{32'h0000_0000, 2'b11, 1'b0, 32'h0000_0020, 32'h0000_0020};
    vecs[4]  = '{32'h1000_FFFF, 2'b10, 1'b1, 32'h0,         32'h0000_0020};
    vecs[5]  = '{32'h1000_FFFF, 2'b10, 1'b0, 32'h0,         32'h0000_0024};
    vecs[6]  = '{32'h0000_0000, 2'b11, 1'b0, 32'h1234_567B, 32'h1234_5678};
    vecs[7]  = '{32'h0000_0000, 2'b00, 1'b0, 32'h0,         32'h1234_567C};
    vecs[8]  = '{32'h0BFF_FFFF, 2'b01, 1'b0, 32'h0,         32'h1FFF_FFFC};
    vecs[9]  = '{32'h1000_0010, 2'b10, 1'b1, 32'h0,         32'h2000_0040};
    vecs[10] = '{32'h0000_0000, 2'b11, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    vecs[11] = '{32'h0000_0000, 2'b00, 1'b0, 32'h0,         32'h0000_0000};

    // Reset and IDLE cycle.
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("idle_req", 32'(imem_req), 32'd0);
    check("idle_ins_valid", 32'(ins_valid), 32'd0);
    check("idle_retired", retired, 32'd0);
    check("idle_pc", pc, 32'd0);
    check("idle_ins", ins, 32'd0);
    check("idle_fault", 32'(fault), 32'd0);
    tick();

    exp_pc  = 32'd0;
    exp_ret = 32'd0;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("v%0d_req", i), 32'(imem_req), 32'd1);
      check($sformatf("v%0d_addr", i), imem_addr, exp_pc);
      imem_valid = 1'b1;
      imem_rdata = vecs[i].rdata;
      tick();
      imem_valid   = 1'b0;
      PCWrite      = 1'b1;
      PCSrc        = vecs[i].src;
      branch_taken = vecs[i].taken;
      reg_target   = vecs[i].target;
      check($sformatf("v%0d_ins_valid", i), 32'(ins_valid), 32'd1);
      check($sformatf("v%0d_ins", i), ins, vecs[i].rdata);
      check($sformatf("v%0d_pc_plus4", i), pc_plus4, exp_pc + 32'd4);
      tick();
      PCWrite = 1'b0;
      exp_pc  = vecs[i].exp_next;
      exp_ret = exp_ret + 32'd1;
      check($sformatf("v%0d_next_addr", i), imem_addr, exp_pc);
      check($sformatf("v%0d_retired", i), retired, exp_ret);
      check($sformatf("v%0d_back_in_fetch", i), 32'(ins_valid), 32'd0);
    end

    // Two-round load: one hold cycle then commit.
    held_ins   = 32'h8C22_0004;
    imem_rdata = held_ins;
    tick();  // one wait state with imem_valid low
    check("lw_wait_req", 32'(imem_req), 32'd1);
    check("lw_wait_addr", imem_addr, exp_pc);
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    PCWrite    = 1'b0;
    PCSrc      = 2'b00;
    tick();
    check("lw_round2_valid", 32'(ins_valid), 32'd1);
    check("lw_round2_ins", ins, held_ins);
    check("lw_round2_retired", retired, exp_ret);
    check("lw_round2_fault", 32'(fault), 32'd0);
    PCWrite = 1'b1;
    tick();
    PCWrite = 1'b0;
    exp_pc  = exp_pc + 32'd4;
    exp_ret = exp_ret + 32'd1;
    check("lw_done_valid", 32'(ins_valid), 32'd0);
    check("lw_done_retired", retired, exp_ret);
    check("lw_done_addr", imem_addr, exp_pc);
    check("lw_done_fault", 32'(fault), 32'd0);

    // Hold limit: fault after three held cycles, sticky through a commit.
    imem_valid = 1'b1;
    imem_rdata = 32'hAC00_0000;
    tick();
    imem_valid = 1'b0;
    tick();
    tick();
    check("hold2_fault", 32'(fault), 32'd0);
    tick();
    check("hold3_fault", 32'(fault), 32'd1);
    check("hold3_ins_valid", 32'(ins_valid), 32'd1);
    tick();
    check("hold4_fault", 32'(fault), 32'd1);
    check("hold4_retired", retired, exp_ret);
    PCWrite = 1'b1;
    tick();
    PCWrite = 1'b0;
    exp_pc  = exp_pc + 32'd4;
    exp_ret = exp_ret + 32'd1;
    check("hold_commit_addr", imem_addr, exp_pc);
    check("hold_commit_fault", 32'(fault), 32'd1);

    // Reset pulsed during the second of three wait states; late valid ignored.
    tick();
    check("rst_wait1_req", 32'(imem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_ins", ins, 32'd0);
    #1 reset = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    tick();
    check("late_valid_ins_valid", 32'(ins_valid), 32'd0);
    check("late_valid_req", 32'(imem_req), 32'd1);
    check("late_valid_ins", ins, 32'd0);
    check("late_valid_addr", imem_addr, 32'd0);
    imem_valid = 1'b0;
    tick();
    check("post_rst_still_fetch", 32'(imem_req), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly upstream of the decode/control unit. Owns the program counter and the instruction register, and fetches 32-bit instructions from instruction memory over a valid handshake. It presents the held instruction as `ins` to the control unit for as many cycles as the control unit keeps `PCWrite` low, so two-round `lw`/`sw` see a stable instruction. It consumes the control unit's `PCWrite`/`PCSrc` to select and commit the next PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `HOLD_LIMIT`, default 3: EXEC cycles without `PCWrite` before `fault` is raised; legal range 2..15.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: reset, asynchronous and active-high.
- `imem_req` out 1: fetch request; high only in FETCH.
- `imem_addr` out 32: fetch address; equals `pc`.
- `imem_valid` in 1: response valid; `imem_rdata` is sampled when this is high in FETCH.
- `imem_rdata` in 32: fetched instruction word.
- `PCWrite` in 1: from control; commits the next PC at the end of the current EXEC cycle.
- `PCSrc` in 2: from control. 00 selects `pc+4`, 01 selects the jal target, 10 selects the branch, 11 selects jr.
- `branch_taken` in 1: comparison result for the branch (bleu); only meaningful when `PCSrc`=10.
- `reg_target` in 32: register operand for jr.
- `ins` out 32: instruction register; drives the control unit.
- `ins_valid` out 1: high in EXEC.
- `pc` out 32: current PC.
- `pc_plus4` out 32: `pc`+4; used as the jal link value.
- `retired` out 32: count of committed instructions.
- `fault` out 1: sticky hold-limit violation.

## Operation
- States: IDLE, FETCH, EXEC. Reset state is IDLE.
- IDLE:
  - Unconditional transition to FETCH on the next edge.
  - `imem_req`=0.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`; both are held stable until the request is accepted.
  - On an edge with `imem_valid`=1: `ins`<=`imem_rdata`, then go to EXEC.
  - Otherwise stay in FETCH with no limit on wait states.
  - `imem_valid` is ignored in all states other than FETCH.
- EXEC:
  - `ins_valid`=1 and `ins` is frozen.
  - On an edge with `PCWrite`=1: `pc`<=next_pc, `retired`+=1 (wraps modulo 2^32), `hold_cnt`<=0, then go to FETCH.
  - On an edge with `PCWrite`=0: stay in EXEC and increment `hold_cnt`, saturating at 15.
  - When `hold_cnt` reaches `HOLD_LIMIT`, `fault`<=1. `fault` is cleared only by reset. The FSM keeps holding; there is no forced advance.
- next_pc (pure 32-bit arithmetic, carries out of bit 31 discarded):
  - 00: `pc+4`.
  - 01: {`pc_plus4`[31:28], `ins`[25:0], 2'b00}.
  - 10: `branch_taken` ? `pc_plus4` + (sign-extended `ins`[15:0] << 2) : `pc_plus4`.
  - 11: {`reg_target`[31:2], 2'b00}; misaligned low bits are forced to zero.
- `PCSrc`, `branch_taken` and `reg_target` are sampled only on the committing edge.

## Timing
- Reset values: state=IDLE, `pc`=`RESET_PC`, `ins`=0, `ins_valid`=0, `imem_req`=0, `retired`=0, `fault`=0, `hold_cnt`=0.
- Asserting `reset` at any point, including mid-FETCH or mid-EXEC, returns every register to its reset value immediately. An outstanding request is abandoned and any late `imem_valid` is ignored until FETCH is re-entered.
- First `imem_req` is high in the second cycle after reset deasserts (IDLE takes one cycle).
- Zero-wait memory (`imem_valid` high in the same cycle as `imem_req`): FETCH lasts 1 cycle. Each single-round instruction then takes 2 cycles (FETCH+EXEC). A two-round `lw`/`sw` takes 3 cycles.
- `ins` changes only on the FETCH→EXEC edge, so it is stable for the entire EXEC dwell.
- `imem_req` and `ins_valid` are decoded from the registered state with no input paths; both are glitch-free.

## Structure
- Package `fetch_pkg`:
  - State enum.
  - `PCSRC_SEQ`/`PCSRC_JAL`/`PCSRC_BR`/`PCSRC_JR` encodings (shared with the control unit).
  - Constant `PC_STEP`=4.
- Sub-module `next_pc_mux`: purely combinational. Takes `pc`, `ins`, `PCSrc`, `branch_taken`, `reg_target` and produces next_pc and `pc_plus4`.
- The FSM, the PC, IR, retire and hold counters, and `fault` live in `fetch_unit`.

## Test plan
- Reset with `RESET_PC`=0 → `imem_req`=0 for one cycle, then 1 with `imem_addr`=0. `ins_valid`=0 and `retired`=0.
- Zero-wait fetch, then EXEC with `PCWrite`=1 and `PCSrc`=00 → next `imem_addr`=0x4 and `retired`=1 after 2 cycles.
- Jal: `pc`=0x200, `ins`[25:0]=0x10, `PCSrc`=01 → next `imem_addr`=0x40.
- Branch: `pc`=0x20, `ins`[15:0]=0xFFFF, `PCSrc`=10. With `branch_taken`=1 → next address 0x20. With `branch_taken`=0 → 0x24.
- Jr: `reg_target`=0x1234_567B → next address 0x1234_5678.
- Two-round load: `PCWrite` 0 then 1 → `ins_valid` high for 2 cycles with `ins` unchanged, exactly one retire, `fault`=0.
- Hold `PCWrite`=0 for 3 cycles → `fault`=1 and stays 1.
- Three `imem_valid` wait cycles with `reset` pulsed in the 2nd → state IDLE and `pc`=`RESET_PC`. A late `imem_valid` is ignored.
